keypad_matrix_scanner: RTL and testbench

//  Input-side counterpart of the multiplexed 7-seg display driver: scans a 4x4 key matrix.

---
 rtl/keypad_matrix_scanner.sv | 172 +++++++++++++++++
 tb/tb_keypad_matrix_scanner.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner
//   Scans a 4x4 active-low key matrix one row at a time, collects a full
//   16-bit frame, and debounces whole frames into single press/release events.
//   Frames with more than one key down are treated as "no valid key" so that
//   ghosted combinations never produce a code.
//
// Ports
//   iCLK        system clock, rising edge
//   iRST_n      asynchronous active-low reset
//   iCOL[3:0]   column inputs, active low, asynchronous to iCLK
//   oROW[3:0]   row drive, active-low one-hot
//   oKEY[3:0]   last accepted key code (row*4 + col), held until the next press
//   oKEY_VALID  one-cycle pulse on an accepted press
//   oKEY_REL    one-cycle pulse on an accepted release
//   oKEY_HELD   high from accepted press to accepted release
module keypad_matrix_scanner #(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       iCLK,
    input  logic       iRST_n,
    input  logic [3:0] iCOL,
    output logic [3:0] oROW,
    output logic [3:0] oKEY,
    output logic       oKEY_VALID,
    output logic       oKEY_REL,
    output logic       oKEY_HELD
);

    localparam int              CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    // dcnt already holds the frames seen so far; the current frame is the
    // last one needed once dcnt reaches DEBOUNCE_FRAMES-1.
    localparam logic [3:0]       DB_M1    = 4'(DEBOUNCE_FRAMES - 1);

    typedef enum logic [1:0] {S_IDLE, S_CAND, S_PRESSED, S_RELEASE} state_t;

    logic [3:0]       col_s1, col_s2;
    logic [CNT_W-1:0] scan_cnt;
    logic [1:0]       row;
    logic [1:0]       row_nxt;
    logic [15:0]      frame;      // 1 = key down
    logic             frame_done;

    logic [4:0]       hit_cnt;
    logic [3:0]       hit_idx;
    logic             single;
    logic             hit_cand;

    state_t           state;
    logic [3:0]       cand;
    logic [3:0]       dcnt;

    // Two-flop synchronizer; idle state is "all columns released".
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            col_s1 <= 4'b1111;
            col_s2 <= 4'b1111;
        end else begin
            col_s1 <= iCOL;
            col_s2 <= col_s1;
        end
    end

    assign row_nxt = row + 2'd1;

    // Row scan. Columns are sampled at the end of each slot so the row drive
    // has had the full slot to settle and pass through the synchronizer.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            scan_cnt   <= '0;
            row        <= 2'd0;
            oROW       <= 4'b1110;
            frame      <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (scan_cnt == CNT_LAST) begin
                scan_cnt                  <= '0;
                frame[{row, 2'b00} +: 4]  <= ~col_s2;
                row                       <= row_nxt;
                oROW                      <= ~(4'b0001 << row_nxt);
                frame_done                <= (row == 2'd3);
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end

    // Frame classification: count set bits and remember the (only) index.
    always_comb begin
        hit_cnt = 5'd0;
        hit_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (frame[i]) begin
                hit_cnt = hit_cnt + 5'd1;
                hit_idx = 4'(i);
            end
        end
    end

    assign single   = (hit_cnt == 5'd1);
    assign hit_cand = single && (hit_idx == cand);

    // Debounce FSM, stepped once per completed frame.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state      <= S_IDLE;
            cand       <= 4'd0;
            dcnt       <= 4'd0;
            oKEY       <= 4'd0;
            oKEY_VALID <= 1'b0;
            oKEY_REL   <= 1'b0;
            oKEY_HELD  <= 1'b0;
        end else begin
            oKEY_VALID <= 1'b0;
            oKEY_REL   <= 1'b0;
            if (frame_done) begin
                case (state)
                    S_IDLE: begin
                        if (single) begin
                            state <= S_CAND;
                            cand  <= hit_idx;
                            dcnt  <= 4'd1;
                        end
                    end
                    S_CAND: begin
                        if (hit_cand) begin
                            if (dcnt >= DB_M1) begin
                                state      <= S_PRESSED;
                                oKEY       <= cand;
                                oKEY_VALID <= 1'b1;
                                oKEY_HELD  <= 1'b1;
                            end else begin
                                dcnt <= dcnt + 4'd1;
                            end
                        end else if (single) begin
                            // a different key took over: restart on it
                            cand <= hit_idx;
                            dcnt <= 4'd1;
                        end else begin
                            state <= S_IDLE;
                            dcnt  <= 4'd0;
                        end
                    end
                    S_PRESSED: begin
                        if (!hit_cand) begin
                            state <= S_RELEASE;
                            dcnt  <= 4'd1;
                        end
                    end
                    S_RELEASE: begin
                        // any frame other than the held key counts toward release,
                        // so a new key must go through IDLE and a fresh CAND run
                        if (hit_cand) begin
                            state <= S_PRESSED;
                        end else if (dcnt >= DB_M1) begin
                            state     <= S_IDLE;
                            dcnt      <= 4'd0;
                            oKEY_REL  <= 1'b1;
                            oKEY_HELD <= 1'b0;
                        end else begin
                            dcnt <= dcnt + 4'd1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb_keypad_matrix_scanner
//   Directed bench for keypad_matrix_scanner with SCAN_DIV=4, DEBOUNCE_FRAMES=3
//   (one frame = 16 clocks). A small matrix model pulls columns low for any
//   pressed key whose row is currently driven low.
module tb_keypad_matrix_scanner;

    logic       iCLK;
    logic       iRST_n;
    logic [3:0] iCOL;
    logic [3:0] oROW;
    logic [3:0] oKEY;
    logic       oKEY_VALID;
    logic       oKEY_REL;
    logic       oKEY_HELD;

    logic [15:0] keys;

    int checks = 0;
    int errors = 0;

    // per-window observations
    int         n_valid, n_rel, n_both, at_valid, at_rel;
    logic [3:0] key_at_valid;

    keypad_matrix_scanner #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(3)) dut (
        .iCLK       (iCLK),
        .iRST_n     (iRST_n),
        .iCOL       (iCOL),
        .oROW       (oROW),
        .oKEY       (oKEY),
        .oKEY_VALID (oKEY_VALID),
        .oKEY_REL   (oKEY_REL),
        .oKEY_HELD  (oKEY_HELD)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // key matrix model
    always_comb begin
        iCOL = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !oROW[r]) iCOL[c] = 1'b0;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // Run n clocks, sampling on falling edges and recording pulses.
    task automatic run_cycles(input int n);
        n_valid = 0; n_rel = 0; n_both = 0; at_valid = -1; at_rel = -1;
        key_at_valid = 4'd0;
        for (int i = 0; i < n; i++) begin
            @(negedge iCLK);
            if (oKEY_VALID) begin n_valid++; at_valid = i; key_at_valid = oKEY; end
            if (oKEY_REL) begin n_rel++; at_rel = i; end
            if (oKEY_VALID && oKEY_REL) n_both++;
        end
    endtask

    // Stop on the falling edge one clock after row 0 is re-driven, the latest
    // point at which a key change still makes the next row-0 sample.
    task automatic align_frame();
        logic [3:0] prev;
        bit found = 0;
        prev = oROW;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge iCLK);
            if (oROW == 4'b1110 && prev == 4'b0111) found = 1;
            prev = oROW;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL align: row 0 start not seen within 64 clocks"); end
        @(negedge iCLK);
    endtask

    task automatic test_reset();
        logic [3:0] exp_row;
        keys = 16'h0000;
        iRST_n = 1'b0;
        repeat (3) @(negedge iCLK);
        checks++;
        if (oROW !== 4'b1110) begin errors++; $display("FAIL reset_row got %b want 1110", oROW); end
        checks++;
        if ({oKEY, oKEY_VALID, oKEY_REL, oKEY_HELD} !== 7'd0) begin
            errors++; $display("FAIL reset_out got key=%0d v=%b r=%b h=%b want 0", oKEY, oKEY_VALID, oKEY_REL, oKEY_HELD);
        end
        iRST_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge iCLK);
            exp_row = ~(4'b0001 << ((k / 4) % 4));
            checks++;
            if (oROW !== exp_row) begin errors++; $display("FAIL scan_row clk %0d got %b want %b", k, oROW, exp_row); end
        end
        run_cycles(64);
        checks++;
        if (n_valid !== 0 || n_rel !== 0) begin
            errors++; $display("FAIL idle_pulses got valid=%0d rel=%0d want 0 0", n_valid, n_rel);
        end
        checks++;
        if (oKEY !== 4'd0 || oKEY_HELD !== 1'b0) begin
            errors++; $display("FAIL idle_out got key=%0d held=%b want 0 0", oKEY, oKEY_HELD);
        end
    endtask

    task automatic test_press();
        align_frame();
        keys = 16'h0200;  // key 9 = row 2, col 1
        run_cycles(32);
        checks++;
        if (n_valid !== 0 || oKEY_HELD !== 1'b0) begin
            errors++; $display("FAIL press_early got valid=%0d held=%b want 0 0", n_valid, oKEY_HELD);
        end
        run_cycles(16);
        checks++;
        if (n_valid !== 1 || at_valid !== 15) begin
            errors++; $display("FAIL press_valid got count=%0d at=%0d want 1 at 15", n_valid, at_valid);
        end
        checks++;
        if (key_at_valid !== 4'd9) begin errors++; $display("FAIL press_key got %0d want 9", key_at_valid); end
        checks++;
        if (oKEY_HELD !== 1'b1) begin errors++; $display("FAIL press_held got %b want 1", oKEY_HELD); end
    endtask

    task automatic test_release_bounce();
        keys = 16'h0000;
        run_cycles(16);
        checks++;
        if (n_valid !== 0 || n_rel !== 0 || oKEY_HELD !== 1'b1) begin
            errors++; $display("FAIL rel_gap got valid=%0d rel=%0d held=%b want 0 0 1", n_valid, n_rel, oKEY_HELD);
        end
        keys = 16'h0200;
        run_cycles(16);
        checks++;
        if (n_valid !== 0 || n_rel !== 0 || oKEY_HELD !== 1'b1) begin
            errors++; $display("FAIL rel_repress got valid=%0d rel=%0d held=%b want 0 0 1", n_valid, n_rel, oKEY_HELD);
        end
        keys = 16'h0000;
        run_cycles(32);
        checks++;
        if (n_rel !== 0 || oKEY_HELD !== 1'b1) begin
            errors++; $display("FAIL rel_early got rel=%0d held=%b want 0 1", n_rel, oKEY_HELD);
        end
        run_cycles(16);
        checks++;
        if (n_rel !== 1 || at_rel !== 15 || n_valid !== 0) begin
            errors++; $display("FAIL rel_pulse got rel=%0d at=%0d valid=%0d want 1 at 15, 0", n_rel, at_rel, n_valid);
        end
        checks++;
        if (oKEY_HELD !== 1'b0 || oKEY !== 4'd9) begin
            errors++; $display("FAIL rel_out got held=%b key=%0d want 0 9", oKEY_HELD, oKEY);
        end
    endtask

    task automatic test_gap_press();
        int total;
        keys = 16'h0200;
        run_cycles(32);
        total = n_valid;
        keys = 16'h0000;
        run_cycles(16);
        total += n_valid;
        checks++;
        if (total !== 0) begin errors++; $display("FAIL gap_first_run got valid=%0d want 0", total); end
        keys = 16'h0200;
        run_cycles(32);
        checks++;
        if (n_valid !== 0) begin errors++; $display("FAIL gap_second_early got valid=%0d want 0", n_valid); end
        run_cycles(16);
        checks++;
        if (n_valid !== 1 || at_valid !== 15 || key_at_valid !== 4'd9) begin
            errors++; $display("FAIL gap_valid got count=%0d at=%0d key=%0d want 1 at 15 key 9", n_valid, at_valid, key_at_valid);
        end
        keys = 16'h0000;
        run_cycles(48);
        checks++;
        if (n_rel !== 1 || at_rel !== 47 || n_both !== 0) begin
            errors++; $display("FAIL gap_release got rel=%0d at=%0d both=%0d want 1 at 47, 0", n_rel, at_rel, n_both);
        end
    endtask

    task automatic test_ghost();
        keys = 16'h0060;  // keys 5 and 6 together
        run_cycles(160);
        checks++;
        if (n_valid !== 0 || n_rel !== 0 || oKEY_HELD !== 1'b0) begin
            errors++; $display("FAIL ghost got valid=%0d rel=%0d held=%b want 0 0 0", n_valid, n_rel, oKEY_HELD);
        end
        checks++;
        if (oKEY !== 4'd9) begin errors++; $display("FAIL ghost_key got %0d want 9", oKEY); end
        keys = 16'h0000;
        run_cycles(32);
    endtask

    task automatic test_reset_mid_press();
        keys = 16'h8000;  // key 15
        run_cycles(48);
        checks++;
        if (n_valid !== 1 || at_valid !== 47 || key_at_valid !== 4'd15) begin
            errors++; $display("FAIL k15_press got count=%0d at=%0d key=%0d want 1 at 47 key 15", n_valid, at_valid, key_at_valid);
        end
        iRST_n = 1'b0;
        #1;
        checks++;
        if ({oKEY, oKEY_VALID, oKEY_REL, oKEY_HELD} !== 7'd0 || oROW !== 4'b1110) begin
            errors++; $display("FAIL midreset_out got key=%0d v=%b r=%b h=%b row=%b want 0 0 0 0 1110",
                               oKEY, oKEY_VALID, oKEY_REL, oKEY_HELD, oROW);
        end
        repeat (3) @(negedge iCLK);
        iRST_n = 1'b1;
        run_cycles(48);
        checks++;
        if (n_valid !== 0 || n_rel !== 0) begin
            errors++; $display("FAIL post_reset_early got valid=%0d rel=%0d want 0 0", n_valid, n_rel);
        end
        run_cycles(1);
        checks++;
        if (n_valid !== 1 || key_at_valid !== 4'd15) begin
            errors++; $display("FAIL post_reset_valid got count=%0d key=%0d want 1 key 15", n_valid, key_at_valid);
        end
        checks++;
        if (oKEY_HELD !== 1'b1) begin errors++; $display("FAIL post_reset_held got %b want 1", oKEY_HELD); end
    endtask

    initial begin
        keys   = 16'h0000;
        iRST_n = 1'b0;
        test_reset();
        test_press();
        test_release_bounce();
        test_gap_press();
        test_ghost();
        test_reset_mid_press();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
